mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, memory address width in bits.
REQ-002 SHALL have parameter MEM_LATENCY, default 1, read latency of attached synchronous memory in cycles (legal 0..7).
REQ-003 sys_clk  in  1  single clock; all logic on rising edge.
REQ-004 reset_n  in  1  reset, synchronous, active-low.
REQ-005 chroni_addr  in  ADDR_WIDTH  video fetch address.
REQ-006 chroni_rd_req  in  1  video read request, level, held until ack.
REQ-007 chroni_dma_req  in  1  video DMA window; blocks CPU grants.
REQ-008 chroni_rd_ack  out  1  one-cycle read-done pulse to video.
REQ-009 cpu_addr  in  ADDR_WIDTH  CPU address.
REQ-010 cpu_rd_req / cpu_wr_req  in  1 each  CPU read / write requests, level, held until ack.
REQ-011 cpu_wr_data  in  8  CPU write byte.
REQ-012 cpu_rd_ack / cpu_wr_ack  out  1 each  one-cycle completion pulses.
REQ-013 rd_data  out  8  registered read byte, shared by both requesters.
REQ-014 mem_addr  out  ADDR_WIDTH; mem_wr_data  out  8; mem_we  out  1; mem_q  in  8  memory port.
REQ-015 busy  out  1  high whenever state is not IDLE.

Function
REQ-016 States SHALL be IDLE, RD_WAIT, WR, DONE.
REQ-017 In IDLE, every cycle, dma_lock SHALL register chroni_dma_req; grants SHALL use the lock value from the previous cycle.
REQ-018 IDLE grant priority SHALL be: chroni_rd_req > cpu_wr_req > cpu_rd_req; CPU requests SHALL be ignored while dma_lock=1.
REQ-019 On grant, mem_addr SHALL register the winner's address and owner register SHALL record requester and operation.
REQ-020 Read grant: IDLE->RD_WAIT; counter SHALL run MEM_LATENCY+1 cycles; on the final edge rd_data<=mem_q and state->DONE.
REQ-021 Write grant: IDLE->WR with mem_wr_data<=cpu_wr_data and mem_we<=1 on the grant edge; next edge mem_we<=0, state->DONE.
REQ-022 mem_we SHALL be high for exactly one cycle per write and never during reads.
REQ-023 In DONE exactly one of chroni_rd_ack, cpu_rd_ack, cpu_wr_ack SHALL be 1 (per owner) for one cycle; next state IDLE.
REQ-024 Read latency: ack high in the cycle starting MEM_LATENCY+2 edges after the IDLE sampling edge (3 for default); write: 2 edges.
REQ-025 rd_data SHALL hold its value until the next read completes; writes SHALL not modify it.
REQ-026 Requests arriving while busy SHALL wait; no request SHALL be dropped while held.
REQ-027 Simultaneous cpu_rd_req and cpu_wr_req SHALL serve the write first.
REQ-028 A requester dropping its request mid-transaction SHALL not abort it; ack still issues.
REQ-029 chroni_dma_req changes while busy SHALL not affect the in-flight transaction.
REQ-030 Addresses SHALL pass unmodified; no wrap or translation.

Reset
REQ-031 With reset_n=0 at a clock edge: state=IDLE, all acks=0, mem_we=0, busy=0, rd_data=0, mem_addr=0, mem_wr_data=0, dma_lock=0.
REQ-032 Reset mid-transaction SHALL abandon it; no ack SHALL issue for it afterwards.

Verification
REQ-033 Single CPU read, MEM_LATENCY=1, memory[0x0123]=0xA5 -> cpu_rd_ack one cycle, 3 edges after IDLE sample, rd_data=0xA5.
REQ-034 chroni_rd_req and cpu_rd_req asserted same cycle -> chroni_rd_ack first; cpu_rd_ack follows after the next full transaction.
REQ-035 chroni_dma_req=1 held, cpu_wr_req to 0x0010 data 0x3C -> no mem_we until dma_req=0; then mem_we one cycle, mem_addr=0x0010, mem_wr_data=0x3C, cpu_wr_ack.
REQ-036 cpu_rd_req and cpu_wr_req both high -> cpu_wr_ack first, then cpu_rd_ack; rd_data unchanged by the write.
REQ-037 reset_n=0 during RD_WAIT -> all outputs at reset values next edge; no ack after release until a new request.
REQ-038 Back-to-back chroni reads of 0x0000..0x00FF -> 256 acks, no ack gaps shorter than 4 cycles, rd_data matching memory each time.

Source files
------------

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter_if
//  Description : Request/acknowledge and memory-port bundle for mem_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if #(
   parameter int ADDR_WIDTH = 16
);
   // Video (chroni) side
   logic [ADDR_WIDTH-1:0] chroni_addr;
   logic                  chroni_rd_req;
   logic                  chroni_dma_req;
   logic                  chroni_rd_ack;

   // CPU side
   logic [ADDR_WIDTH-1:0] cpu_addr;
   logic                  cpu_rd_req;
   logic                  cpu_wr_req;
   logic [7:0]            cpu_wr_data;
   logic                  cpu_rd_ack;
   logic                  cpu_wr_ack;

   // Shared read data, memory port and status
   logic [7:0]            rd_data;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [7:0]            mem_wr_data;
   logic                  mem_we;
   logic [7:0]            mem_q;
   logic                  busy;

   // Arbiter side
   modport slave (
      input  chroni_addr,
      input  chroni_rd_req,
      input  chroni_dma_req,
      output chroni_rd_ack,
      input  cpu_addr,
      input  cpu_rd_req,
      input  cpu_wr_req,
      input  cpu_wr_data,
      output cpu_rd_ack,
      output cpu_wr_ack,
      output rd_data,
      output mem_addr,
      output mem_wr_data,
      output mem_we,
      input  mem_q,
      output busy
   );

   // Requester / memory side
   modport master (
      output chroni_addr,
      output chroni_rd_req,
      output chroni_dma_req,
      input  chroni_rd_ack,
      output cpu_addr,
      output cpu_rd_req,
      output cpu_wr_req,
      output cpu_wr_data,
      input  cpu_rd_ack,
      input  cpu_wr_ack,
      input  rd_data,
      input  mem_addr,
      input  mem_wr_data,
      input  mem_we,
      output mem_q,
      input  busy
   );
endinterface : mem_arbiter_if
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Single-port memory arbiter between video fetch and CPU.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
   parameter int ADDR_WIDTH  = 16,
   parameter int MEM_LATENCY = 1
) (
   input  wire logic    sys_clk,
   input  wire logic    reset_n,
   mem_arbiter_if.slave bus
);

   localparam logic [1:0] c_st_idle    = 2'd0;
   localparam logic [1:0] c_st_rd_wait = 2'd1;
   localparam logic [1:0] c_st_wr      = 2'd2;
   localparam logic [1:0] c_st_done    = 2'd3;

   localparam logic [1:0] c_own_chroni_rd = 2'd0;
   localparam logic [1:0] c_own_cpu_rd    = 2'd1;
   localparam logic [1:0] c_own_cpu_wr    = 2'd2;

   localparam logic [2:0] c_last_cnt = 3'(MEM_LATENCY);

   generate
      if (MEM_LATENCY < 0 || MEM_LATENCY > 7) begin : g_bad_latency
         $error("mem_arbiter: MEM_LATENCY must be in 0..7");
      end
   endgenerate

   logic [1:0]            r_state;
   logic [1:0]            w_state_nxt;
   logic [1:0]            r_owner;
   logic [2:0]            r_cnt;
   logic                  r_dma_lock;
   logic [7:0]            r_rd_data;
   logic [ADDR_WIDTH-1:0] r_mem_addr;
   logic [7:0]            r_mem_wr_data;
   logic                  r_mem_we;

   logic                  w_grant_chroni;
   logic                  w_grant_cpu_wr;
   logic                  w_grant_cpu_rd;
   logic                  w_rd_last;

   logic                  w_chroni_rd_ack;
   logic                  w_cpu_rd_ack;
   logic                  w_cpu_wr_ack;
   logic                  w_busy;

   // Grants see the lock captured on the previous cycle, not the live DMA request.
   assign w_grant_chroni = bus.chroni_rd_req;
   assign w_grant_cpu_wr = !bus.chroni_rd_req && !r_dma_lock && bus.cpu_wr_req;
   assign w_grant_cpu_rd = !bus.chroni_rd_req && !r_dma_lock && !bus.cpu_wr_req
                           && bus.cpu_rd_req;
   assign w_rd_last      = (r_cnt == c_last_cnt);

   // State register
   always_ff @(posedge sys_clk) begin
      if (!reset_n) begin
         r_state <= c_st_idle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_st_idle: begin
            if (w_grant_chroni || w_grant_cpu_rd) begin
               w_state_nxt = c_st_rd_wait;
            end else if (w_grant_cpu_wr) begin
               w_state_nxt = c_st_wr;
            end
         end
         c_st_rd_wait: begin
            if (w_rd_last) begin
               w_state_nxt = c_st_done;
            end
         end
         c_st_wr:   w_state_nxt = c_st_done;
         c_st_done: w_state_nxt = c_st_idle;
         default:   w_state_nxt = c_st_idle;
      endcase
   end

   // Output logic: acknowledges are a pure function of DONE and the recorded owner
   always_comb begin
      w_chroni_rd_ack = 1'b0;
      w_cpu_rd_ack    = 1'b0;
      w_cpu_wr_ack    = 1'b0;
      w_busy          = (r_state != c_st_idle);
      if (r_state == c_st_done) begin
         case (r_owner)
            c_own_chroni_rd: w_chroni_rd_ack = 1'b1;
            c_own_cpu_rd:    w_cpu_rd_ack    = 1'b1;
            c_own_cpu_wr:    w_cpu_wr_ack    = 1'b1;
            default: begin
               w_chroni_rd_ack = 1'b0;
            end
         endcase
      end
   end

   // Datapath: address/owner capture, latency counter, write strobe, read data
   always_ff @(posedge sys_clk) begin
      if (!reset_n) begin
         r_owner       <= c_own_chroni_rd;
         r_cnt         <= 3'd0;
         r_dma_lock    <= 1'b0;
         r_rd_data     <= 8'd0;
         r_mem_addr    <= '0;
         r_mem_wr_data <= 8'd0;
         r_mem_we      <= 1'b0;
      end else begin
         case (r_state)
            c_st_idle: begin
               r_dma_lock <= bus.chroni_dma_req;
               r_cnt      <= 3'd0;
               if (w_grant_chroni) begin
                  r_mem_addr <= bus.chroni_addr;
                  r_owner    <= c_own_chroni_rd;
               end else if (w_grant_cpu_wr) begin
                  r_mem_addr    <= bus.cpu_addr;
                  r_owner       <= c_own_cpu_wr;
                  r_mem_wr_data <= bus.cpu_wr_data;
                  r_mem_we      <= 1'b1;
               end else if (w_grant_cpu_rd) begin
                  r_mem_addr <= bus.cpu_addr;
                  r_owner    <= c_own_cpu_rd;
               end
            end
            c_st_rd_wait: begin
               if (w_rd_last) begin
                  r_rd_data <= bus.mem_q;
               end else begin
                  r_cnt <= r_cnt + 3'd1;
               end
            end
            c_st_wr: begin
               r_mem_we <= 1'b0;
            end
            default: begin
               r_mem_we <= 1'b0;
            end
         endcase
      end
   end

   assign bus.chroni_rd_ack = w_chroni_rd_ack;
   assign bus.cpu_rd_ack    = w_cpu_rd_ack;
   assign bus.cpu_wr_ack    = w_cpu_wr_ack;
   assign bus.busy          = w_busy;
   assign bus.rd_data       = r_rd_data;
   assign bus.mem_addr      = r_mem_addr;
   assign bus.mem_wr_data   = r_mem_wr_data;
   assign bus.mem_we        = r_mem_we;

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Scoreboard testbench for mem_arbiter with a 1-cycle memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

   localparam int c_aw = 16;

   typedef struct {
      int         kind;   // 0 chroni read, 1 cpu read, 2 cpu write
      logic [7:0] data;   // rd_data expected while the ack is high
   } exp_t;

   typedef struct {
      logic [15:0] addr;
      logic [7:0]  data;
   } wexp_t;

   logic sys_clk = 1'b0;
   logic reset_n = 1'b0;
   logic mem_init = 1'b1;

   mem_arbiter_if #(.ADDR_WIDTH(c_aw)) bus ();

   mem_arbiter #(
      .ADDR_WIDTH  (c_aw),
      .MEM_LATENCY (1)
   ) dut (
      .sys_clk (sys_clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 sys_clk = ~sys_clk;

   int   checks = 0;
   int   errors = 0;
   exp_t  sbq[$];
   wexp_t wq[$];
   int   we_count = 0;
   int   chroni_ack_count = 0;
   int   cyc = 0;
   int   last_chroni_cyc = -100;
   logic [7:0] last_rd = 8'h00;

   // Initial memory image
   function automatic logic [7:0] init_mem(input logic [15:0] a);
      if (a == 16'h0123) return 8'hA5;
      return 8'(a[7:0] * 8'd3) ^ 8'h5C ^ a[15:8];
   endfunction

   // Synchronous memory, one cycle of read latency
   logic [7:0] mem [0:65535];
   logic [7:0] q_r;
   always @(posedge sys_clk) begin
      if (mem_init) begin
         for (int i = 0; i < 65536; i++) mem[i] <= init_mem(16'(i));
      end else if (bus.mem_we) begin
         mem[bus.mem_addr] <= bus.mem_wr_data;
      end
      q_r <= mem[bus.mem_addr];
   end
   assign bus.mem_q = q_r;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents an ack or a write strobe
   always @(negedge sys_clk) begin
      exp_t  e;
      wexp_t w;
      int    kind;
      cyc++;
      if (reset_n && (bus.chroni_rd_ack || bus.cpu_rd_ack || bus.cpu_wr_ack)) begin
         kind = bus.chroni_rd_ack ? 0 : (bus.cpu_rd_ack ? 1 : 2);
         checks++;
         if (!$onehot({bus.chroni_rd_ack, bus.cpu_rd_ack, bus.cpu_wr_ack})) begin
            errors++;
            $display("FAIL ack_onehot: got acks %b, expected exactly one",
                     {bus.chroni_rd_ack, bus.cpu_rd_ack, bus.cpu_wr_ack});
         end else if (sbq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_ack: got ack kind %0d, expected none", kind);
         end else begin
            e = sbq.pop_front();
            if (e.kind != kind || bus.rd_data !== e.data) begin
               errors++;
               $display("FAIL ack_match: got kind %0d rd_data %02h, expected kind %0d rd_data %02h",
                        kind, bus.rd_data, e.kind, e.data);
            end
         end
         if (kind == 0) begin
            chroni_ack_count++;
            checks++;
            if (cyc - last_chroni_cyc < 4) begin
               errors++;
               $display("FAIL chroni_ack_gap: got %0d cycles, expected >= 4",
                        cyc - last_chroni_cyc);
            end
            last_chroni_cyc = cyc;
         end
      end
      if (bus.mem_we === 1'b1) begin
         we_count++;
         checks++;
         if (wq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_we: got write %04h=%02h, expected none",
                     bus.mem_addr, bus.mem_wr_data);
         end else begin
            w = wq.pop_front();
            if (bus.mem_addr !== w.addr || bus.mem_wr_data !== w.data) begin
               errors++;
               $display("FAIL mem_write: got %04h=%02h, expected %04h=%02h",
                        bus.mem_addr, bus.mem_wr_data, w.addr, w.data);
            end
         end
      end
   end

   function automatic logic ack_of(input int kind);
      case (kind)
         0:       return bus.chroni_rd_ack;
         1:       return bus.cpu_rd_ack;
         default: return bus.cpu_wr_ack;
      endcase
   endfunction

   // Holds one request until its ack; exp_lat > 0 also checks edge count to the ack
   task automatic txn(input int kind, input logic [15:0] a, input logic [7:0] d,
                      input int exp_lat);
      int n;
      logic got;
      n   = 0;
      got = 1'b0;
      case (kind)
         0: begin bus.chroni_addr = a; bus.chroni_rd_req = 1'b1; end
         1: begin bus.cpu_addr = a; bus.cpu_rd_req = 1'b1; end
         default: begin bus.cpu_addr = a; bus.cpu_wr_data = d; bus.cpu_wr_req = 1'b1; end
      endcase
      while (!got && n < 50) begin
         @(posedge sys_clk);
         n++;
         @(negedge sys_clk);
         if (ack_of(kind)) got = 1'b1;
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL timeout kind %0d addr %04h: got no ack, expected one", kind, a);
      end else if (exp_lat > 0) begin
         chk($sformatf("latency_k%0d_%04h", kind, a), n, exp_lat);
      end
      @(posedge sys_clk);
      #1;
      case (kind)
         0:       bus.chroni_rd_req = 1'b0;
         1:       bus.cpu_rd_req    = 1'b0;
         default: bus.cpu_wr_req    = 1'b0;
      endcase
   endtask

   task automatic push_rd(input int kind, input logic [7:0] d);
      sbq.push_back('{kind: kind, data: d});
      last_rd = d;
   endtask

   task automatic push_wr(input logic [15:0] a, input logic [7:0] d);
      sbq.push_back('{kind: 2, data: last_rd});
      wq.push_back('{addr: a, data: d});
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_busy"},        bus.busy, 1'b0);
      chk({tag, "_acks"},        {bus.chroni_rd_ack, bus.cpu_rd_ack, bus.cpu_wr_ack}, 3'b000);
      chk({tag, "_mem_we"},      bus.mem_we, 1'b0);
      chk({tag, "_rd_data"},     bus.rd_data, 8'h00);
      chk({tag, "_mem_addr"},    bus.mem_addr, 16'h0000);
      chk({tag, "_mem_wr_data"}, bus.mem_wr_data, 8'h00);
   endtask

   initial begin
      int ack0;
      int we0;
      bus.chroni_addr    = '0;
      bus.chroni_rd_req  = 1'b0;
      bus.chroni_dma_req = 1'b0;
      bus.cpu_addr       = '0;
      bus.cpu_rd_req     = 1'b0;
      bus.cpu_wr_req     = 1'b0;
      bus.cpu_wr_data    = 8'h00;

      repeat (3) @(posedge sys_clk);
      @(negedge sys_clk);
      check_reset_outputs("reset");
      @(posedge sys_clk);
      #1;
      reset_n  = 1'b1;
      mem_init = 1'b0;
      @(posedge sys_clk);
      #1;

      // Single CPU read of the marked location
      push_rd(1, 8'hA5);
      txn(1, 16'h0123, 8'h00, 3);

      // Back-to-back video reads over a full page
      ack0 = chroni_ack_count;
      for (int i = 0; i < 256; i++) begin
         push_rd(0, init_mem(16'(i)));
         txn(0, 16'(i), 8'h00, 3);
      end
      chk("chroni_ack_total", chroni_ack_count - ack0, 256);

      // Video and CPU read in the same cycle: video first, CPU one transaction later
      push_rd(0, init_mem(16'h0055));
      push_rd(1, init_mem(16'h0077));
      fork
         txn(0, 16'h0055, 8'h00, 3);
         txn(1, 16'h0077, 8'h00, 7);
      join

      // CPU write held off by a DMA window
      bus.chroni_dma_req = 1'b1;
      repeat (2) @(posedge sys_clk);
      #1;
      we0 = we_count;
      push_wr(16'h0010, 8'h3C);
      fork
         txn(2, 16'h0010, 8'h3C, 0);
         begin
            repeat (6) @(posedge sys_clk);
            #1;
            chk("dma_blocks_we", we_count, we0);
            bus.chroni_dma_req = 1'b0;
         end
      join
      chk("dma_write_count", we_count - we0, 1);
      push_rd(1, 8'h3C);
      txn(1, 16'h0010, 8'h00, 3);

      // Simultaneous CPU read and write: write first, read sees the new byte
      push_wr(16'h0020, 8'h5A);
      push_rd(1, 8'h5A);
      fork
         txn(2, 16'h0020, 8'h5A, 2);
         txn(1, 16'h0020, 8'h00, 6);
      join

      // Reset while a read is waiting on memory
      bus.chroni_addr   = 16'h0040;
      bus.chroni_rd_req = 1'b1;
      @(posedge sys_clk);
      #1;
      reset_n = 1'b0;
      @(posedge sys_clk);
      @(negedge sys_clk);
      check_reset_outputs("midreset");
      @(posedge sys_clk);
      #1;
      bus.chroni_rd_req = 1'b0;
      reset_n           = 1'b1;
      repeat (10) @(posedge sys_clk);
      @(negedge sys_clk);
      chk("post_reset_idle", bus.busy, 1'b0);
      chk("sb_drained", sbq.size() + wq.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no end of test, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_mem_arbiter
`default_nettype wire
